// File: rtl/gfx_pkg.sv
// Shared graphics types and constants.
//   owner_t : which requester owns the VRAM port
//   state_t : arbiter FSM states
//   burst_t : burst latched in the pick cycle (owner, base byte address, beats-1)
//   VRAM_BEAT_BYTES : address step between consecutive burst beats
package gfx_pkg;

    typedef enum logic {OWN_BG, OWN_OBJ} owner_t;
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [31:0] VRAM_BEAT_BYTES = 32'd4;

    typedef struct packed {
        owner_t      owner;
        logic [31:0] base;
        logic [1:0]  len;
    } burst_t;

endpackage

// File: rtl/vram_rr_picker.sv
// Combinational round-robin choice between the BG and OBJ requesters.
//   bg_req, obj_req : request lines
//   last_owner      : owner of the previous pick
//   any             : at least one request is pending
//   owner           : chosen requester (only meaningful when any = 1)
module vram_rr_picker
    import gfx_pkg::*;
(
    input  logic   bg_req,
    input  logic   obj_req,
    input  owner_t last_owner,
    output logic   any,
    output owner_t owner
);

    always_comb begin
        any = bg_req | obj_req;
        if (bg_req && obj_req)
            owner = (last_owner == OWN_BG) ? OWN_OBJ : OWN_BG;
        else if (obj_req)
            owner = OWN_OBJ;
        else
            owner = OWN_BG;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester VRAM burst arbiter (BG and OBJ fetch units).
// A burst is picked in IDLE, then one beat per cycle is issued in BURST.
// Read data returns one cycle after the address and is tagged to its owner.
//   clock, reset            : clock, synchronous active-high reset
//   flush                   : scanline restart, aborts any burst in flight
//   bg_req/addr/len         : BG burst request (len = beats-1)
//   obj_req/addr/len        : OBJ burst request
//   bg_gnt, obj_gnt         : beat issued for that requester this cycle
//   bg_rvalid, obj_rvalid   : rdata belongs to that requester this cycle
//   rdata                   : passthrough of VRAM_mem_data
//   VRAM_mem_addr           : read address (0 when no beat issues)
//   VRAM_mem_data           : read data, one cycle after its address
module vram_arbiter
    import gfx_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        bg_req,
    input  logic [31:0] bg_addr,
    input  logic [1:0]  bg_len,
    input  logic        obj_req,
    input  logic [31:0] obj_addr,
    input  logic [1:0]  obj_len,
    output logic        bg_gnt,
    output logic        obj_gnt,
    output logic        bg_rvalid,
    output logic        obj_rvalid,
    output logic [31:0] rdata,
    output logic [31:0] VRAM_mem_addr,
    input  logic [31:0] VRAM_mem_data
);

    state_t     state, state_nxt;
    burst_t     cur;
    burst_t     pick_burst;
    logic [1:0] beat;
    owner_t     last_owner;
    logic       pick_any;
    owner_t     pick_owner;
    logic       issue;
    // read-return tag: a beat issued last cycle returns data this cycle
    logic       rv_vld;
    owner_t     rv_own;

    vram_rr_picker u_pick (
        .bg_req     (bg_req),
        .obj_req    (obj_req),
        .last_owner (last_owner),
        .any        (pick_any),
        .owner      (pick_owner)
    );

    always_comb begin
        pick_burst.owner = pick_owner;
        pick_burst.base  = (pick_owner == OWN_OBJ) ? obj_addr : bg_addr;
        pick_burst.len   = (pick_owner == OWN_OBJ) ? obj_len  : bg_len;
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (pick_any)         state_nxt = BURST;
                BURST:   if (beat == cur.len)  state_nxt = IDLE;
                default:                       state_nxt = IDLE;
            endcase
        end
    end

    // outputs
    always_comb begin
        issue         = (state == BURST) && !flush;
        bg_gnt        = issue && (cur.owner == OWN_BG);
        obj_gnt       = issue && (cur.owner == OWN_OBJ);
        VRAM_mem_addr = issue ? cur.base + 32'(beat) * VRAM_BEAT_BYTES : 32'd0;
        bg_rvalid     = rv_vld && (rv_own == OWN_BG);
        obj_rvalid    = rv_vld && (rv_own == OWN_OBJ);
        rdata         = VRAM_mem_data;
    end

    // burst datapath, beat counter and read-return tag
    always_ff @(posedge clock) begin
        if (reset) begin
            cur        <= '{owner: OWN_BG, base: 32'd0, len: 2'd0};
            beat       <= 2'd0;
            last_owner <= OWN_OBJ;   // so BG wins the first tie
            rv_vld     <= 1'b0;
            rv_own     <= OWN_BG;
        end else begin
            // flush never kills data already in flight: issue is 0 in the
            // flush cycle, but rv_vld from the previous beat is still shown
            rv_vld <= issue;
            rv_own <= cur.owner;
            if (flush) begin
                beat <= 2'd0;
            end else if (state == IDLE && pick_any) begin
                cur        <= pick_burst;
                beat       <= 2'd0;
                last_owner <= pick_owner;
            end else if (issue) begin
                beat <= (beat == cur.len) ? 2'd0 : beat + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset, flush;
    logic        bg_req, obj_req;
    logic [31:0] bg_addr, obj_addr;
    logic [1:0]  bg_len, obj_len;
    logic        bg_gnt, obj_gnt, bg_rvalid, obj_rvalid;
    logic [31:0] rdata, VRAM_mem_addr;
    logic [31:0] mem_data = 32'd0;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    // VRAM model: data for an address appears one cycle later
    always @(posedge clock) mem_data <= VRAM_mem_addr ^ KEY;

    vram_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .bg_req        (bg_req),
        .bg_addr       (bg_addr),
        .bg_len        (bg_len),
        .obj_req       (obj_req),
        .obj_addr      (obj_addr),
        .obj_len       (obj_len),
        .bg_gnt        (bg_gnt),
        .obj_gnt       (obj_gnt),
        .bg_rvalid     (bg_rvalid),
        .obj_rvalid    (obj_rvalid),
        .rdata         (rdata),
        .VRAM_mem_addr (VRAM_mem_addr),
        .VRAM_mem_data (mem_data)
    );

    always @(negedge clock) begin
        if (!reset) begin
            assert (!(bg_gnt && obj_gnt));
            assert (!(bg_rvalid && obj_rvalid));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    // ctl = {bg_gnt, obj_gnt, bg_rvalid, obj_rvalid}; src = address whose data returns
    task automatic exp_cyc(input string tag, input logic [3:0] ctl,
                           input logic [31:0] a, input logic [31:0] src);
        #1;
        chk({tag, "_ctl"}, {28'd0, bg_gnt, obj_gnt, bg_rvalid, obj_rvalid}, {28'd0, ctl});
        chk({tag, "_addr"}, VRAM_mem_addr, a);
        if (ctl[1] | ctl[0]) chk({tag, "_rd"}, rdata, src ^ KEY);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        bg_req = 1'b0; obj_req = 1'b0;
        bg_addr = 32'd0; obj_addr = 32'd0; bg_len = 2'd0; obj_len = 2'd0;
        nxt(); nxt();
        reset = 1'b0;
        exp_cyc("rst", 4'b0000, 32'd0, 32'd0);
        chk("rst_rdpass", rdata, mem_data);

        // BG only, 4 beats
        bg_req = 1'b1; bg_addr = 32'h0600_0000; bg_len = 2'd3;
        exp_cyc("bg_pick", 4'b0000, 32'd0, 32'd0);
        nxt(); bg_req = 1'b0; bg_addr = 32'hDEAD_BEEF; bg_len = 2'd0;
        exp_cyc("bg_b0", 4'b1000, 32'h0600_0000, 32'd0);
        nxt(); exp_cyc("bg_b1", 4'b1010, 32'h0600_0004, 32'h0600_0000);
        nxt(); exp_cyc("bg_b2", 4'b1010, 32'h0600_0008, 32'h0600_0004);
        nxt(); exp_cyc("bg_b3", 4'b1010, 32'h0600_000C, 32'h0600_0008);
        nxt(); exp_cyc("bg_end", 4'b0010, 32'd0, 32'h0600_000C);
        nxt(); exp_cyc("bg_idle", 4'b0000, 32'd0, 32'd0);

        // address wrap
        bg_req = 1'b1; bg_addr = 32'hFFFF_FFFC; bg_len = 2'd1;
        exp_cyc("wr_pick", 4'b0000, 32'd0, 32'd0);
        nxt(); bg_req = 1'b0;
        exp_cyc("wr_b0", 4'b1000, 32'hFFFF_FFFC, 32'd0);
        nxt(); exp_cyc("wr_b1", 4'b1010, 32'h0000_0000, 32'hFFFF_FFFC);
        nxt(); exp_cyc("wr_end", 4'b0010, 32'd0, 32'h0000_0000);

        // OBJ burst aborted by flush on beat 2
        nxt(); obj_req = 1'b1; obj_addr = 32'h0000_0300; obj_len = 2'd3;
        exp_cyc("fl_pick", 4'b0000, 32'd0, 32'd0);
        nxt(); obj_req = 1'b0;
        exp_cyc("fl_b0", 4'b0100, 32'h0000_0300, 32'd0);
        nxt(); exp_cyc("fl_b1", 4'b0101, 32'h0000_0304, 32'h0000_0300);
        nxt(); flush = 1'b1;
        exp_cyc("fl_cyc", 4'b0001, 32'd0, 32'h0000_0304);
        // flush in IDLE blocks the pick
        nxt(); bg_req = 1'b1; obj_req = 1'b1;
        bg_addr = 32'h0000_0500; obj_addr = 32'h0000_0600; bg_len = 2'd0; obj_len = 2'd0;
        exp_cyc("fl_nopick", 4'b0000, 32'd0, 32'd0);
        nxt(); flush = 1'b0;
        exp_cyc("fl_pick2", 4'b0000, 32'd0, 32'd0);
        // last_owner kept as OBJ across flush, so BG wins the tie
        nxt(); bg_req = 1'b0; obj_req = 1'b0;
        exp_cyc("fl_rr", 4'b1000, 32'h0000_0500, 32'd0);
        nxt(); exp_cyc("fl_rrend", 4'b0010, 32'd0, 32'h0000_0500);

        // reset mid-burst (last_owner is BG before reset)
        bg_req = 1'b1; bg_addr = 32'h0000_0400; bg_len = 2'd3;
        nxt(); bg_req = 1'b0;
        exp_cyc("rm_b0", 4'b1000, 32'h0000_0400, 32'd0);
        nxt(); reset = 1'b1;
        exp_cyc("rm_b1", 4'b1010, 32'h0000_0404, 32'h0000_0400);
        nxt(); reset = 1'b0;
        bg_req = 1'b1; obj_req = 1'b1;
        bg_addr = 32'h0000_0100; obj_addr = 32'h0000_0200; bg_len = 2'd0; obj_len = 2'd0;
        exp_cyc("rm_after", 4'b0000, 32'd0, 32'd0);

        // tie after reset: strict alternation starting with BG
        for (int k = 0; k < 4; k++) begin
            nxt();
            if (k == 3) begin bg_req = 1'b0; obj_req = 1'b0; end
            if (k % 2 == 0) exp_cyc($sformatf("tie%0d", k), 4'b1000, 32'h0000_0100, 32'd0);
            else            exp_cyc($sformatf("tie%0d", k), 4'b0100, 32'h0000_0200, 32'd0);
            nxt();
            if (k % 2 == 0) exp_cyc($sformatf("tie%0d_rv", k), 4'b0010, 32'd0, 32'h0000_0100);
            else            exp_cyc($sformatf("tie%0d_rv", k), 4'b0001, 32'd0, 32'h0000_0200);
        end
        nxt(); exp_cyc("tie_idle", 4'b0000, 32'd0, 32'd0);

        // random traffic: exclusivity and idle address
        for (int i = 0; i < 300; i++) begin
            nxt();
            bg_req   = 1'($urandom_range(1, 0));
            obj_req  = 1'($urandom_range(1, 0));
            bg_len   = 2'($urandom_range(3, 0));
            obj_len  = 2'($urandom_range(3, 0));
            bg_addr  = $urandom;
            obj_addr = $urandom;
            flush    = ($urandom_range(7, 0) == 0);
            #1;
            chk("rnd_gnt_x", {31'd0, bg_gnt & obj_gnt}, 32'd0);
            chk("rnd_rv_x", {31'd0, bg_rvalid & obj_rvalid}, 32'd0);
            if (!bg_gnt && !obj_gnt) chk("rnd_idle_addr", VRAM_mem_addr, 32'd0);
            if (flush) chk("rnd_flush_gnt", {31'd0, bg_gnt | obj_gnt}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock in, reset in; all state updates on posedge clock; reset sampled only at posedge clock.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- flush  in  1  scanline restart (startrow pulse); aborts current burst
- bg_req  in  1  BG requester wants a burst
- bg_addr  in  32  BG burst base byte address
- bg_len  in  2  BG burst beats minus 1 (1..4 beats)
- obj_req  in  1  OBJ requester wants a burst
- obj_addr  in  32  OBJ burst base byte address
- obj_len  in  2  OBJ burst beats minus 1
- bg_gnt  out  1  BG beat issued this cycle
- obj_gnt  out  1  OBJ beat issued this cycle
- bg_rvalid  out  1  rdata belongs to BG this cycle
- obj_rvalid  out  1  rdata belongs to OBJ this cycle
- rdata  out  32  read data, passthrough of VRAM_mem_data
- VRAM_mem_addr  out  32  VRAM read address
- VRAM_mem_data  in  32  VRAM read data, valid 1 cycle after address

Function
REQ-003 States SHALL be IDLE and BURST; no VRAM access is issued in IDLE.
REQ-004 In IDLE with no flush, if any req is high, the block SHALL pick an owner, latch owner, base addr and len, clear beat counter, and go to BURST; otherwise stay IDLE.
REQ-005 Pick SHALL be round-robin: only one req -> that one; both -> the requester that is not last_owner; last_owner updates on every pick.
REQ-006 In BURST, each cycle SHALL issue one beat: VRAM_mem_addr = base + 4*beat (32-bit add, wraps modulo 2^32, low two bits of base preserved); owner gnt = 1, other gnt = 0.
REQ-007 When beat == len in BURST, the block SHALL return to IDLE next cycle; an n-beat burst therefore occupies n+1 cycles including the IDLE pick cycle.
REQ-008 req/addr/len SHALL be sampled only in the IDLE pick cycle; changes during BURST have no effect; a requester holds req until its first gnt, and a req still high after its last beat is treated as a new request.
REQ-009 Read return SHALL be fixed latency 1: for a beat issued in cycle N, owner rvalid = 1 in cycle N+1 with rdata = VRAM_mem_data; rdata passes through combinationally in every cycle.
REQ-010 When no beat issues, VRAM_mem_addr SHALL be 0 and both gnt SHALL be 0.
REQ-011 flush SHALL take priority in every state: no beat issues in the flush cycle, state -> IDLE, beat counter -> 0, no pick that cycle; last_owner retained.
REQ-012 A beat issued in the cycle before flush SHALL still produce its rvalid in the flush cycle; flush never kills returning data.
REQ-013 bg_gnt and obj_gnt SHALL never both be 1; bg_rvalid and obj_rvalid SHALL never both be 1.

Reset
REQ-014 While reset is high at posedge clock: state = IDLE, beat = 0, owner = BG, base = 0, len = 0, rvalid pipeline = 0, last_owner = OBJ (BG wins the first tie).
REQ-015 In the cycle after reset deasserts, all outputs SHALL be 0 except rdata, which still follows VRAM_mem_data; reset mid-burst SHALL abandon the burst with no further gnt or rvalid.
REQ-016 reset SHALL override flush and all requests.

Structure
REQ-017 The owner enum {OWN_BG, OWN_OBJ}, state enum {IDLE, BURST} and constant VRAM_BEAT_BYTES = 4 SHALL live in shared package gfx_pkg.
REQ-018 Round-robin selection SHALL be a combinational sub-module vram_rr_picker (inputs bg_req, obj_req, last_owner; outputs any, owner).
REQ-019 Beat counter and rvalid delay register SHALL be in vram_arbiter itself; no other sub-modules.

Verification
REQ-020 BG only: bg_req=1, bg_addr=0x0600_0000, bg_len=3 -> pick cycle, then addresses 0x0600_0000/04/08/0C with bg_gnt=1 on 4 consecutive cycles, bg_rvalid on the 4 following-by-one cycles, then IDLE.
REQ-021 Tie after reset: both req, len=0 held -> BG beat, IDLE, OBJ beat, IDLE, BG beat, ... strict alternation.
REQ-022 Flush mid-burst: OBJ len=3, flush on beat 2 cycle -> beats 0,1 issued, no beat in flush cycle, obj_rvalid for beat 1 in flush cycle, state IDLE, last_owner = OBJ.
REQ-023 Wrap: bg_addr=0xFFFF_FFFC, bg_len=1 -> addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-024 Reset mid-burst: BG len=3, reset on beat 1 -> no gnt/rvalid after reset cycle; next tie goes to BG; assertions on REQ-013 across random traffic.
